// File: rtl/varredura_matriz.sv
// varredura_matriz: 5x7 LED matrix column scanner with a double-buffered frame.
// Defining VARREDURA_BRILHO_EN adds a 3-bit brilho input that trims the lit part of each column.
module varredura_matriz #(
    parameter int DIV       = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch1,
    input  logic        ch0,
    input  logic [34:0] quadro,
    input  logic        carregar,
`ifdef VARREDURA_BRILHO_EN
    input  logic [2:0]  brilho,
`endif
    output logic [6:0]  acender_coluna,
    output logic [4:0]  saida_linha,
    output logic        quadro_fim,
    output logic        pendente
);

    localparam int PW = $clog2(DIV);
    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLANK_CYC - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [2:0]    col, col_nxt;
    logic [34:0]   ativo, sombra;
    logic [1:0]    modo;
    logic          frame_end;
    logic          janela;
    logic [5:0]    idx;
    logic [6:0]    coluna_nxt;
    logic [4:0]    linha_nxt;

    assign modo = {ch1, ch0};
    assign idx  = {1'b0, col, 2'b00} + {3'b000, col};

`ifdef VARREDURA_BRILHO_EN
    assign janela = (int'(pre) < (int'(brilho) + 1) * (DIV / 8));
`else
    assign janela = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK;
            pre   <= '0;
            bcnt  <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            pre   <= pre_nxt;
            bcnt  <= bcnt_nxt;
            col   <= col_nxt;
        end
    end

    // Freeze (01) holds the whole sequencer; every other mode keeps it running.
    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        bcnt_nxt  = bcnt;
        col_nxt   = col;
        frame_end = 1'b0;
        if (modo != 2'b01) begin
            unique case (state)
                DRIVE: begin
                    if (pre == PRE_LAST) begin
                        state_nxt = BLANK;
                        pre_nxt   = '0;
                        col_nxt   = (col == 3'd6) ? 3'd0 : col + 3'd1;
                        frame_end = (col == 3'd6);
                    end else begin
                        pre_nxt = pre + PW'(1);
                    end
                end
                BLANK: begin
                    if (bcnt == BLK_LAST) begin
                        state_nxt = DRIVE;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt = bcnt + BW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        coluna_nxt = '0;
        linha_nxt  = '0;
        unique case (modo)
            2'b10: begin
                coluna_nxt = '0;
                linha_nxt  = '0;
            end
            2'b11: begin
                coluna_nxt = 7'h7F;
                linha_nxt  = 5'h1F;
            end
            default: begin
                if (state == DRIVE && janela) begin
                    coluna_nxt = 7'b000_0001 << col;
                    linha_nxt  = ativo[idx +: 5];
                end
            end
        endcase
    end

    // A load landing on the swap cycle is kept in the shadow and stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ativo          <= '0;
            sombra         <= '0;
            pendente       <= 1'b0;
            acender_coluna <= '0;
            saida_linha    <= '0;
            quadro_fim     <= 1'b0;
        end else begin
            acender_coluna <= coluna_nxt;
            saida_linha    <= linha_nxt;
            quadro_fim     <= frame_end;
            if (carregar)
                sombra <= quadro;
            if (frame_end && pendente) begin
                ativo    <= sombra;
                pendente <= carregar;
            end else if (carregar) begin
                pendente <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_varredura_matriz.sv
// Directed testbench for varredura_matriz with DIV=16, BLANK_CYC=2 (126-cycle frame).
module tb_varredura_matriz;

    logic        clk = 1'b0;
    logic        reset;
    logic        ch1, ch0;
    logic [34:0] quadro;
    logic        carregar;
`ifdef VARREDURA_BRILHO_EN
    logic [2:0]  brilho;
`endif
    logic [6:0]  acender_coluna;
    logic [4:0]  saida_linha;
    logic        quadro_fim;
    logic        pendente;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [34:0] DADO_A   = 35'h0_0000_0415;
    localparam logic [34:0] DADO_B   = 35'h0_0000_0C0A;
    localparam logic [34:0] DADO_ALL = 35'h7_FFFF_FFFF;

    always #5 clk = ~clk;

    varredura_matriz #(.DIV(16), .BLANK_CYC(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .ch1            (ch1),
        .ch0            (ch0),
        .quadro         (quadro),
        .carregar       (carregar),
`ifdef VARREDURA_BRILHO_EN
        .brilho         (brilho),
`endif
        .acender_coluna (acender_coluna),
        .saida_linha    (saida_linha),
        .quadro_fim     (quadro_fim),
        .pendente       (pendente)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fim();
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (quadro_fim !== 1'b1 && n < 400);
        vectors++;
        if (quadro_fim !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_fim: quadro_fim=%b after %0d cycles, required 1", quadro_fim, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        vectors++; if (acender_coluna !== 7'h00) begin miscompares++; $display("FAIL reset_col: got %h want 00", acender_coluna); end
        vectors++; if (saida_linha !== 5'h00) begin miscompares++; $display("FAIL reset_row: got %h want 00", saida_linha); end
        vectors++; if (quadro_fim !== 1'b0) begin miscompares++; $display("FAIL reset_fim: got %b want 0", quadro_fim); end
        vectors++; if (pendente !== 1'b0) begin miscompares++; $display("FAIL reset_pend: got %b want 0", pendente); end
        reset = 1'b0;
        tick(2);
        vectors++; if (acender_coluna !== 7'h00) begin miscompares++; $display("FAIL first_dark: got %h want 00", acender_coluna); end
        tick(1);
        vectors++; if (acender_coluna !== 7'h01) begin miscompares++; $display("FAIL first_lit: got %h want 01", acender_coluna); end
    endtask

    // Picks up at column 0, drive cycle 0 (third cycle after reset release).
    task automatic test_scan();
        for (int p = 1; p <= 252; p++) begin
            int q, c, r;
            logic [6:0] exp_col;
            logic       exp_fim;
            q = p % 126;
            c = q / 18;
            r = q % 18;
            exp_col = (r < 16) ? (7'h01 << c) : 7'h00;
            exp_fim = (q == 123);
            tick(1);
            vectors++;
            if (acender_coluna !== exp_col) begin
                miscompares++;
                $display("FAIL scan_col p=%0d: got %h want %h", p, acender_coluna, exp_col);
            end
            vectors++;
            if (quadro_fim !== exp_fim) begin
                miscompares++;
                $display("FAIL scan_fim p=%0d: got %b want %b", p, quadro_fim, exp_fim);
            end
            vectors++;
            if (saida_linha !== 5'h00) begin
                miscompares++;
                $display("FAIL scan_row p=%0d: got %h want 00", p, saida_linha);
            end
        end
    endtask

    task automatic test_swap();
        wait_fim();
        tick(57);
        vectors++; if (acender_coluna !== 7'h08) begin miscompares++; $display("FAIL swap_col3: got %h want 08", acender_coluna); end
        quadro = DADO_ALL; carregar = 1'b1;
        tick(1);
        carregar = 1'b0;
        vectors++; if (pendente !== 1'b1) begin miscompares++; $display("FAIL swap_pend_set: got %b want 1", pendente); end
        vectors++; if (saida_linha !== 5'h00) begin miscompares++; $display("FAIL swap_row_old: got %h want 00", saida_linha); end
        tick(67);
        vectors++; if (acender_coluna !== 7'h40) begin miscompares++; $display("FAIL swap_col6: got %h want 40", acender_coluna); end
        vectors++; if (pendente !== 1'b1) begin miscompares++; $display("FAIL swap_pend_hold: got %b want 1", pendente); end
        tick(1);
        vectors++; if (quadro_fim !== 1'b1) begin miscompares++; $display("FAIL swap_fim: got %b want 1", quadro_fim); end
        vectors++; if (pendente !== 1'b0) begin miscompares++; $display("FAIL swap_pend_clr: got %b want 0", pendente); end
        vectors++; if (saida_linha !== 5'h00) begin miscompares++; $display("FAIL swap_row_last: got %h want 00", saida_linha); end
        tick(2);
        vectors++; if (acender_coluna !== 7'h00) begin miscompares++; $display("FAIL swap_blank: got %h want 00", acender_coluna); end
        tick(1);
        vectors++; if (acender_coluna !== 7'h01) begin miscompares++; $display("FAIL swap_newcol: got %h want 01", acender_coluna); end
        vectors++; if (saida_linha !== 5'h1F) begin miscompares++; $display("FAIL swap_newrow: got %h want 1F", saida_linha); end
    endtask

    // Entered at column 0, drive cycle 0; next frame end is 123 cycles later.
    task automatic test_coincident();
        quadro = DADO_A; carregar = 1'b1;
        tick(1);
        carregar = 1'b0;
        vectors++; if (pendente !== 1'b1) begin miscompares++; $display("FAIL coin_pend_a: got %b want 1", pendente); end
        tick(121);
        quadro = DADO_B; carregar = 1'b1;
        tick(1);
        carregar = 1'b0;
        vectors++; if (quadro_fim !== 1'b1) begin miscompares++; $display("FAIL coin_fim: got %b want 1", quadro_fim); end
        vectors++; if (pendente !== 1'b1) begin miscompares++; $display("FAIL coin_pend_b: got %b want 1", pendente); end
        tick(3);
        vectors++; if (acender_coluna !== 7'h01) begin miscompares++; $display("FAIL coin_col_a: got %h want 01", acender_coluna); end
        vectors++; if (saida_linha !== 5'h15) begin miscompares++; $display("FAIL coin_row_a: got %h want 15", saida_linha); end
        tick(122);
        vectors++; if (pendente !== 1'b1) begin miscompares++; $display("FAIL coin_pend_keep: got %b want 1", pendente); end
        tick(1);
        vectors++; if (quadro_fim !== 1'b1) begin miscompares++; $display("FAIL coin_fim2: got %b want 1", quadro_fim); end
        vectors++; if (pendente !== 1'b0) begin miscompares++; $display("FAIL coin_pend_clr: got %b want 0", pendente); end
        tick(3);
        vectors++; if (saida_linha !== 5'h0A) begin miscompares++; $display("FAIL coin_row_b: got %h want 0A", saida_linha); end
    endtask

    // Entered at column 0, drive cycle 0 with frame B displayed.
    task automatic test_freeze();
        tick(42);
        vectors++; if (acender_coluna !== 7'h04) begin miscompares++; $display("FAIL frz_pre_col: got %h want 04", acender_coluna); end
        ch1 = 1'b0; ch0 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            vectors++;
            if (acender_coluna !== 7'h04 || saida_linha !== 5'h03 || quadro_fim !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze i=%0d: got col=%h row=%h fim=%b want 04/03/0", i, acender_coluna, saida_linha, quadro_fim);
            end
        end
        ch0 = 1'b0;
    endtask

    task automatic test_blank_mode();
        int fims = 0;
        ch1 = 1'b1; ch0 = 1'b0;
        for (int i = 0; i < 126; i++) begin
            tick(1);
            if (quadro_fim === 1'b1) fims++;
            vectors++;
            if (acender_coluna !== 7'h00 || saida_linha !== 5'h00) begin
                miscompares++;
                $display("FAIL blank_mode i=%0d: got col=%h row=%h want 00/00", i, acender_coluna, saida_linha);
            end
        end
        vectors++;
        if (fims !== 1) begin miscompares++; $display("FAIL blank_fim_count: got %0d want 1", fims); end
    endtask

    task automatic test_lamp();
        ch1 = 1'b1; ch0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            vectors++;
            if (acender_coluna !== 7'h7F || saida_linha !== 5'h1F) begin
                miscompares++;
                $display("FAIL lamp i=%0d: got col=%h row=%h want 7F/1F", i, acender_coluna, saida_linha);
            end
        end
        ch1 = 1'b0; ch0 = 1'b0;
    endtask

    task automatic test_async_reset();
        wait_fim();
        tick(93);
        vectors++; if (acender_coluna !== 7'h20) begin miscompares++; $display("FAIL ar_col5: got %h want 20", acender_coluna); end
        quadro = DADO_ALL; carregar = 1'b1;
        tick(1);
        carregar = 1'b0;
        vectors++; if (pendente !== 1'b1) begin miscompares++; $display("FAIL ar_pend: got %b want 1", pendente); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (acender_coluna !== 7'h00) begin miscompares++; $display("FAIL ar_col_now: got %h want 00", acender_coluna); end
        vectors++; if (saida_linha !== 5'h00) begin miscompares++; $display("FAIL ar_row_now: got %h want 00", saida_linha); end
        vectors++; if (pendente !== 1'b0) begin miscompares++; $display("FAIL ar_pend_now: got %b want 0", pendente); end
        tick(2);
        reset = 1'b0;
        tick(2);
        vectors++; if (acender_coluna !== 7'h00) begin miscompares++; $display("FAIL ar_dark: got %h want 00", acender_coluna); end
        tick(1);
        vectors++; if (acender_coluna !== 7'h01) begin miscompares++; $display("FAIL ar_first: got %h want 01", acender_coluna); end
        vectors++; if (saida_linha !== 5'h00) begin miscompares++; $display("FAIL ar_row_cleared: got %h want 00", saida_linha); end
        vectors++; if (pendente !== 1'b0) begin miscompares++; $display("FAIL ar_pend_lost: got %b want 0", pendente); end
    endtask

`ifdef VARREDURA_BRILHO_EN
    task automatic test_brightness();
        brilho = 3'd1;
        wait_fim();
        tick(3);
        for (int r = 0; r < 18; r++) begin
            logic [6:0] exp_col;
            if (r > 0) tick(1);
            exp_col = (r < 4) ? 7'h01 : 7'h00;
            vectors++;
            if (acender_coluna !== exp_col) begin
                miscompares++;
                $display("FAIL bright r=%0d: got %h want %h", r, acender_coluna, exp_col);
            end
        end
        tick(1);
        vectors++; if (acender_coluna !== 7'h02) begin miscompares++; $display("FAIL bright_next: got %h want 02", acender_coluna); end
        brilho = 3'd7;
    endtask
`endif

    initial begin
        reset = 1'b1; ch1 = 1'b0; ch0 = 1'b0; quadro = '0; carregar = 1'b0;
`ifdef VARREDURA_BRILHO_EN
        brilho = 3'd7;
`endif
        test_reset();
        test_scan();
        test_swap();
        test_coincident();
        test_freeze();
        test_blank_mode();
        test_lamp();
        test_async_reset();
`ifdef VARREDURA_BRILHO_EN
        test_brightness();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
